// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 32;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a pending producer, accepts
// reserves, and keeps a running count of busy registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = clog2(DEFAULT_DEPTH)
) (
    input  logic          clock,
    input  logic          ctrl_reset,
    input  logic          wr_accept,
    input  logic [AW-1:0] wr_addr,
    input  logic          rsv_req,
    input  logic [AW-1:0] rsv_addr,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic          reserve_ok,
    output logic          busy_a,
    output logic          busy_b,
    output logic [AW:0]   busy_count
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             rsv_ok;
    logic             wr_clear;

    assign rsv_ok   = rsv_req && !ctrl_reset && (rsv_addr != '0) && !busy_q[rsv_addr];
    assign wr_clear = wr_accept && busy_q[wr_addr];

    // Register 0 never carries a busy bit.
    assign set_vec[0] = 1'b0;
    assign clr_vec[0] = 1'b1;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_bits
            assign set_vec[gi] = rsv_ok && (rsv_addr == AW'(gi));
            assign clr_vec[gi] = wr_clear && (wr_addr == AW'(gi));
        end
    endgenerate

    always_comb begin
        busy_d  = (busy_q & ~clr_vec) | set_vec;
        count_d = count_q;
        case ({rsv_ok, wr_clear})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign reserve_ok = rsv_ok;
    assign busy_a     = busy_q[rd_addr_a];
    assign busy_b     = busy_q[rd_addr_b];
    assign busy_count = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with a reservation scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_writeEnable,
    input  logic [AW-1:0]    ctrl_writeReg,
    input  logic [WIDTH-1:0] data_writeReg,
    input  logic [AW-1:0]    ctrl_readRegA,
    input  logic [AW-1:0]    ctrl_readRegB,
    output logic [WIDTH-1:0] data_readRegA,
    output logic [WIDTH-1:0] data_readRegB,
    input  logic             ctrl_reserve,
    input  logic [AW-1:0]    ctrl_reserveReg,
    output logic             reserve_ok,
    output logic             busy_A,
    output logic             busy_B,
    output logic [AW:0]      busy_count
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             wr_accept;

    logic [AW-1:0]    rd_addr  [2];
    logic [WIDTH-1:0] rd_data  [2];
    logic             rd_busy_stored [2];
    logic             rd_busy  [2];
    logic             rd_hit   [2];

    assign wr_accept = ctrl_writeEnable && (ctrl_writeReg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_accept) begin
            regs_d[ctrl_writeReg] = data_writeReg;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .wr_accept  (wr_accept),
        .wr_addr    (ctrl_writeReg),
        .rsv_req    (ctrl_reserve),
        .rsv_addr   (ctrl_reserveReg),
        .rd_addr_a  (ctrl_readRegA),
        .rd_addr_b  (ctrl_readRegB),
        .reserve_ok (reserve_ok),
        .busy_a     (rd_busy_stored[0]),
        .busy_b     (rd_busy_stored[1]),
        .busy_count (busy_count)
    );

    assign rd_addr[0] = ctrl_readRegA;
    assign rd_addr[1] = ctrl_readRegB;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
`ifdef REGFILE_SB_BYPASS_EN
            // Forwarding is suppressed during reset so every output reads zero.
            assign rd_hit[gi] = wr_accept && !ctrl_reset && (rd_addr[gi] == ctrl_writeReg);
`else
            assign rd_hit[gi] = 1'b0;
`endif
            assign rd_data[gi] = rd_hit[gi] ? data_writeReg : regs_q[rd_addr[gi]];
            assign rd_busy[gi] = rd_hit[gi] ? 1'b0 : rd_busy_stored[gi];
        end
    endgenerate

    assign data_readRegA = rd_data[0];
    assign data_readRegB = rd_data[1];
    assign busy_A        = rd_busy[0];
    assign busy_B        = rd_busy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb (default 32x32 configuration).
module tb_regfile_sb;

    logic        clock;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        ctrl_reserve;
    logic [4:0]  ctrl_reserveReg;
    logic        reserve_ok;
    logic        busy_A;
    logic        busy_B;
    logic [5:0]  busy_count;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_sb dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .ctrl_reserve     (ctrl_reserve),
        .ctrl_reserveReg  (ctrl_reserveReg),
        .reserve_ok       (reserve_ok),
        .busy_A           (busy_A),
        .busy_B           (busy_B),
        .busy_count       (busy_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        rsv;
        logic [4:0]  raddr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_ba;
        logic        exp_bb;
        logic        exp_ok;
        logic [5:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic rsv, input logic [4:0] raddr);
        ctrl_writeEnable = we;
        ctrl_writeReg    = waddr;
        data_writeReg    = wdata;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        ctrl_reserve     = rsv;
        ctrl_reserveReg  = raddr;
    endtask

    task automatic check_all(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                             input logic eba, input logic ebb, input logic eok, input logic [5:0] ecnt);
        check({tag, ".data_a"}, data_readRegA, ea);
        check({tag, ".data_b"}, data_readRegB, eb);
        check({tag, ".busy_a"}, 32'(busy_A), 32'(eba));
        check({tag, ".busy_b"}, 32'(busy_B), 32'(ebb));
        check({tag, ".rsv_ok"}, 32'(reserve_ok), 32'(eok));
        check({tag, ".count"}, 32'(busy_count), 32'(ecnt));
    endtask

    initial begin
        //                we  wa     wdata          ra     rb     rsv rr     exp_a          exp_b          ba  bb  ok  cnt
        vecs.push_back('{1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 1'b0, 5'd0, 32'h0,        32'h0,        1'b0,1'b0,1'b0,6'd0});
        vecs.push_back('{1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0, 5'd0, 32'h0,        32'h0,        1'b0,1'b0,1'b0,6'd0});
        vecs.push_back('{1'b1, 5'd0, 32'h1234,     5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0,1'b0,1'b0,6'd0});
        vecs.push_back('{1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 1'b0,1'b0,1'b0,6'd0});
        vecs.push_back('{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 5'd7, 32'h0,        32'h0,        1'b0,1'b0,1'b1,6'd0});
        vecs.push_back('{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1, 5'd7, 32'h0,        32'h0,        1'b1,1'b0,1'b0,6'd1});
        vecs.push_back('{1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b0, 5'd0, 32'h0,        32'h0,        1'b1,1'b0,1'b0,6'd1});
        vecs.push_back('{1'b1, 5'd7, 32'h77,       5'd3, 5'd5, 1'b1, 5'd3, 32'h0,        32'hDEADBEEF, 1'b0,1'b0,1'b1,6'd1});
        vecs.push_back('{1'b0, 5'd0, 32'h0,        5'd3, 5'd7, 1'b0, 5'd0, 32'h0,        32'h77,       1'b1,1'b0,1'b0,6'd1});
        vecs.push_back('{1'b1, 5'd3, 32'h33,       5'd7, 5'd5, 1'b1, 5'd3, 32'h77,       32'hDEADBEEF, 1'b0,1'b0,1'b0,6'd1});
        vecs.push_back('{1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 1'b0, 5'd0, 32'h33,       32'h0,        1'b0,1'b0,1'b0,6'd0});
        vecs.push_back('{1'b1, 5'd6, 32'h66,       5'd1, 5'd2, 1'b0, 5'd0, 32'h0,        32'h0,        1'b0,1'b0,1'b0,6'd0});
        vecs.push_back('{1'b0, 5'd0, 32'h0,        5'd6, 5'd3, 1'b0, 5'd0, 32'h66,       32'h33,       1'b0,1'b0,1'b0,6'd0});
        vecs.push_back('{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd0, 32'h0,        32'h0,        1'b0,1'b0,1'b0,6'd0});
        vecs.push_back('{1'b1, 5'd1, 32'h11,       5'd2, 5'd3, 1'b1, 5'd1, 32'h0,        32'h33,       1'b0,1'b0,1'b1,6'd0});
        vecs.push_back('{1'b0, 5'd0, 32'h0,        5'd1, 5'd3, 1'b0, 5'd0, 32'h11,       32'h33,       1'b1,1'b0,1'b0,6'd1});
        vecs.push_back('{1'b1, 5'd9, 32'h1,        5'd1, 5'd0, 1'b0, 5'd0, 32'h11,       32'h0,        1'b1,1'b0,1'b0,6'd1});

        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        ctrl_reset = 1'b1;
        repeat (2) @(negedge clock);
        ctrl_reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ra, vecs[i].rb,
                  vecs[i].rsv, vecs[i].raddr);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_ba,
                      vecs[i].exp_bb, vecs[i].exp_ok, vecs[i].exp_cnt);
            $display("vec%0d: we=%0d wr=r%0d ra=r%0d rb=r%0d rsv=%0d r%0d -> a=%08h b=%08h cnt=%0d",
                     i, vecs[i].we, vecs[i].waddr, vecs[i].ra, vecs[i].rb, vecs[i].rsv,
                     vecs[i].raddr, data_readRegA, data_readRegB, busy_count);
        end

        // Write r9 while reading it on port B.
        @(negedge clock);
        drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd0, 5'd9, 1'b0, 5'd0);
        #1;
        check_all("byp_same", 32'h0, BYPASS ? 32'hA5A5A5A5 : 32'h1, 1'b0, 1'b0, 1'b0, 6'd1);
        $display("byp_same: b=%08h", data_readRegB);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0);
        #1;
        check_all("byp_next", 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 6'd1);
        $display("byp_next: b=%08h", data_readRegB);

        // Write busy r1 while reading it: busy visible unless forwarded.
        @(negedge clock);
        drive(1'b1, 5'd1, 32'hB1, 5'd0, 5'd1, 1'b0, 5'd0);
        #1;
        check_all("byp_busy", 32'h0, BYPASS ? 32'hB1 : 32'h11, 1'b0, !BYPASS, 1'b0, 6'd1);
        $display("byp_busy: b=%08h busy_b=%0d", data_readRegB, busy_B);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 1'b0, 5'd0);
        #1;
        check_all("byp_busy_next", 32'h0, 32'hB1, 1'b0, 1'b0, 1'b0, 6'd0);
        $display("byp_busy_next: b=%08h cnt=%0d", data_readRegB, busy_count);

        // Reserve r2 and r4, then pulse reset mid-cycle with a reserve pending.
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd2);
        #1;
        check("rst_rsv2.ok", 32'(reserve_ok), 32'd1);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd4);
        #1;
        check("rst_rsv4.ok", 32'(reserve_ok), 32'd1);
        @(negedge clock);
        drive(1'b1, 5'd9, 32'h99, 5'd5, 5'd4, 1'b1, 5'd6);
        #1;
        check_all("rst_pre", 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1'b1, 6'd2);
        $display("rst_pre: a=%08h busy_b=%0d cnt=%0d", data_readRegA, busy_B, busy_count);
        #1;
        ctrl_reset = 1'b1;
        #1;
        check_all("rst_mid", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
        $display("rst_mid: a=%08h b=%08h cnt=%0d", data_readRegA, data_readRegB, busy_count);
        @(negedge clock);
        ctrl_reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd6, 1'b0, 5'd0);
        #1;
        check_all("rst_post", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
        $display("rst_post: a=%08h busy_b=%0d cnt=%0d", data_readRegA, busy_B, busy_count);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 5'd2, 5'd4, 1'b0, 5'd0);
        #1;
        check_all("rst_post2", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
        $display("rst_post2: busy_a=%0d busy_b=%0d cnt=%0d", busy_A, busy_B, busy_count);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
